// File: rtl/pong_pkg.sv
// Shared encodings for the pong score keeper: FSM states, digit field offsets
// and serve directions.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int unsigned DIG_P1_TENS = 12;
  localparam int unsigned DIG_P1_ONES = 8;
  localparam int unsigned DIG_P2_TENS = 4;
  localparam int unsigned DIG_P2_ONES = 0;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter with a parallel binary count, saturating at 99.
module bcd2_counter (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] bin
);

  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [6:0] bin_q;
  logic       at_max_c;

  assign at_max_c = (bin_q == 7'd99);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      bin_q  <= 7'd0;
    end else if (clear) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      bin_q  <= 7'd0;
    end else if (inc && !at_max_c) begin
      bin_q <= bin_q + 7'd1;
      if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign bin  = bin_q;

endmodule

// File: rtl/pong_score.sv
// Pong score keeper and match-flow controller: conditions start/hit inputs,
// keeps both BCD scores and sequences serve delay, play and game over.
module pong_score
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_DELAY = 25000000,
  parameter int unsigned CW          = 25
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        hit_left,
  input  logic        hit_right,
  input  logic        start,
  output logic [15:0] digits,
  output logic        play_en,
  output logic        serve_dir,
  output logic        game_over,
  output logic        winner,
  output logic [1:0]  state
);

  localparam logic [CW-1:0] LOAD = CW'(SERVE_DELAY - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          start_s1_q, start_s2_q, start_s3_q;
  logic          hit_left_prev_q, hit_right_prev_q;
  logic          play_en_q, serve_dir_q, game_over_q, winner_q;

  logic          start_rise_c, hl_rise_c, hr_rise_c;
  logic          p1_pt_c, p2_pt_c, clear_c;
  logic          p1_win_c, p2_win_c;
  logic [3:0]    p1_tens, p1_ones, p2_tens, p2_ones;
  logic [6:0]    p1_bin, p2_bin;

  // Edge detection and scoring decisions for the current cycle
  always_comb begin
    start_rise_c = start_s2_q & ~start_s3_q;
    hl_rise_c    = hit_left & ~hit_left_prev_q;
    hr_rise_c    = hit_right & ~hit_right_prev_q;
    p1_pt_c      = (state_q == ST_PLAY) & hr_rise_c & ~hl_rise_c;
    p2_pt_c      = (state_q == ST_PLAY) & hl_rise_c & ~hr_rise_c;
    clear_c      = start_rise_c & ((state_q == ST_IDLE) | (state_q == ST_OVER));
    p1_win_c     = ((p1_bin + 7'd1) == 7'(WIN_SCORE));
    p2_win_c     = ((p2_bin + 7'd1) == 7'(WIN_SCORE));
  end

  bcd2_counter u_p1 (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (clear_c),
    .inc   (p1_pt_c),
    .tens  (p1_tens),
    .ones  (p1_ones),
    .bin   (p1_bin)
  );

  bcd2_counter u_p2 (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (clear_c),
    .inc   (p2_pt_c),
    .tens  (p2_tens),
    .ones  (p2_ones),
    .bin   (p2_bin)
  );

  // Hit-prev flops reset high so a hit already asserted at release is not a point
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      start_s1_q       <= 1'b0;
      start_s2_q       <= 1'b0;
      start_s3_q       <= 1'b0;
      hit_left_prev_q  <= 1'b1;
      hit_right_prev_q <= 1'b1;
      play_en_q        <= 1'b0;
      serve_dir_q      <= SERVE_LEFT;
      game_over_q      <= 1'b0;
      winner_q         <= 1'b0;
    end else begin
      start_s1_q       <= start;
      start_s2_q       <= start_s1_q;
      start_s3_q       <= start_s2_q;
      hit_left_prev_q  <= hit_left;
      hit_right_prev_q <= hit_right;
      case (state_q)
        ST_IDLE: begin
          if (start_rise_c) begin
            cnt_q   <= LOAD;
            state_q <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (cnt_q == '0) begin
            state_q   <= ST_PLAY;
            play_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_PLAY: begin
          if (hl_rise_c && hr_rise_c) begin
            play_en_q <= 1'b0;
            cnt_q     <= LOAD;
            state_q   <= ST_SERVE;
          end else if (hl_rise_c || hr_rise_c) begin
            play_en_q   <= 1'b0;
            serve_dir_q <= hl_rise_c ? SERVE_LEFT : SERVE_RIGHT;
            if ((p2_pt_c && p2_win_c) || (p1_pt_c && p1_win_c)) begin
              game_over_q <= 1'b1;
              winner_q    <= p2_pt_c;
              state_q     <= ST_OVER;
            end else begin
              cnt_q   <= LOAD;
              state_q <= ST_SERVE;
            end
          end
        end
        ST_OVER: begin
          if (start_rise_c) begin
            game_over_q <= 1'b0;
            cnt_q       <= LOAD;
            state_q     <= ST_SERVE;
          end
        end
      endcase
    end
  end

  always_comb begin
    digits = 16'h0000;
    digits[DIG_P1_TENS +: 4] = p1_tens;
    digits[DIG_P1_ONES +: 4] = p1_ones;
    digits[DIG_P2_TENS +: 4] = p2_tens;
    digits[DIG_P2_ONES +: 4] = p2_ones;
  end

  assign play_en   = play_en_q;
  assign serve_dir = serve_dir_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: doc/pong_score.md
Name: pong_score

Overview:
Score keeper and match-flow controller. Sits downstream of gameplay and upstream of segdisplay, in the dclk domain.
- Consumes gameplay's ball-exit indications and the start button.
- Keeps both players' scores as 2-digit BCD and drives the 4-digit word shown by segdisplay.
- Gates ball motion through a serve delay, a play phase and a game-over phase.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99.
SERVE_DELAY, 25000000, cycles that play_en stays low before each serve (1 s at 25 MHz dclk); minimum 1.
CW, 25, serve-delay counter width; must satisfy 2^CW > SERVE_DELAY.

Ports:
clk  in  1  system clock (dclk from clockdiv).
clr_n  in  1  asynchronous, active-low reset.
hit_left  in  1  level; ball left the field on the left edge, which is a point to P2 (right paddle).
hit_right  in  1  level; ball left the field on the right edge, which is a point to P1 (left paddle).
start  in  1  raw, asynchronous pushbutton level.
digits  out  16  BCD: [15:12] P1 tens, [11:8] P1 ones, [7:4] P2 tens, [3:0] P2 ones.
play_en  out  1  high only in PLAY; gameplay freezes the ball when this is low.
serve_dir  out  1  direction of the next serve: 0 = toward P1 (left), 1 = toward P2 (right).
game_over  out  1  high in OVER.
winner  out  1  0 = P1, 1 = P2; meaningful only while game_over is high.
state  out  2  FSM state, for debug.

Behaviour:
Reset (clr_n low) acts immediately, without waiting for a clock edge:
- digits = 16'h0000; play_en, serve_dir, game_over, winner = 0; state = IDLE.
- Delay counter = 0; start synchroniser flops = 0.
- hit_left/hit_right previous-value registers = 1, so a hit level already high at reset release is not scored.

Input conditioning:
- start passes through a 2-flop synchroniser, then a rising-edge detector. start_rise is therefore a 1-cycle pulse, 3 clk edges after start rises.
- hit_x_rise = hit_x & ~hit_x_prev, with hit_x_prev updated every cycle. A level held for N cycles produces exactly one point.

FSM (encoding IDLE=0, SERVE=1, PLAY=2, OVER=3):
- IDLE: play_en=0. On start_rise: clear both scores, load counter with SERVE_DELAY-1, go to SERVE.
- SERVE: play_en=0. Counter decrements each cycle; in the cycle the counter reads 0, go to PLAY. Hit edges are ignored here, but prev registers keep tracking.
- PLAY: play_en=1.
  - hit_left_rise alone: P2 score +1, serve_dir <= 0.
  - hit_right_rise alone: P1 score +1, serve_dir <= 1.
  - After a single point: if the incremented binary score equals WIN_SCORE, go to OVER and set winner; otherwise reload the counter and go to SERVE.
  - Both rises in the same cycle: no score change, serve_dir unchanged, reload counter, go to SERVE (point replayed).
- OVER: game_over=1, play_en=0, scores and winner held, hits ignored. On start_rise: clear scores, game_over <= 0, reload counter, go to SERVE.
- start_rise in SERVE or PLAY is ignored.

Latency:
- A score increment appears on digits after the first clk edge at which hit_x is sampled high (1 cycle).
- play_en falls on that same edge.

Arithmetic:
- Each score is held as a 7-bit binary count, used for the WIN_SCORE compare, plus a 2-digit BCD value.
- BCD increment: when ones = 9, ones <= 0 and tens +1; otherwise ones +1.
- Scores saturate at 99. This is unreachable while WIN_SCORE <= 99, but is still required.

Mid-operation reset: clr_n assertion in any state forces the reset values at once. After release the block waits in IDLE for start.

Decomposition:
- Shared package pong_pkg holds:
  - state encodings ST_IDLE, ST_SERVE, ST_PLAY, ST_OVER;
  - digit field offsets DIG_P1_TENS=12, DIG_P1_ONES=8, DIG_P2_TENS=4, DIG_P2_ONES=0;
  - SERVE_LEFT=0, SERVE_RIGHT=1.
- One sub-module, bcd2_counter (clk, clr_n, clear, inc, tens[3:0], ones[3:0], bin[6:0], with saturation at 99), instantiated once per player.

Test Plan:
- Reset scoring guard: hold hit_left=1 through reset release -> digits stays 16'h0000 and state=IDLE for 20 cycles.
- Serve timing (SERVE_DELAY=4): pulse start -> state=SERVE 3 cycles after start rises; play_en rises exactly 4 cycles after entering SERVE.
- Single-count and latency: in PLAY, hold hit_left high for 5 cycles -> digits=16'h0001 after 1 edge, incremented once only, serve_dir=0, state=SERVE.
- BCD carry: P1 scores 10 points (WIN_SCORE=11) -> digits=16'h1000; the 11th point -> game_over=1, winner=0, state=OVER.
- Game over and restart (WIN_SCORE=3): P2 scores 3 -> digits=16'h0003, winner=1; further hits leave digits unchanged; start -> digits=16'h0000, game_over=0, state=SERVE.
- Simultaneous hits and mid-serve reset: hit_left and hit_right rise in the same cycle -> digits unchanged, state=SERVE; assert clr_n low mid-SERVE -> all outputs return to reset values before the next clk edge.
